input_port_controller: RTL
==========================

Name: input_port_controller

Overview:
- Producer side of the processor's IN-instruction data path: supplies the 32-bit word the processor reads from the board switches, with a confirm handshake.
- Synchronises the 18 switches and a raw push-button, then debounces the button.
- When the processor raises a read request, waits for a debounced press, captures the switches into a data register and returns a one-cycle ready pulse. The processor stalls on request && !input_ready.

Parameters:
SWITCH_WIDTH, 18, width of the switch bus
DATA_WIDTH, 32, width of input_data; must be >= SWITCH_WIDTH
DEBOUNCE_CYCLES, 1000, consecutive stable clocks required before the debounced button level changes; minimum 1

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  reset
switches  input  SWITCH_WIDTH  raw board switches, asynchronous
button_n  input  1  raw confirm key, active-low (0 = pressed), asynchronous
input_request  input  1  level from the control unit; high while an IN instruction is waiting
input_data  output  DATA_WIDTH  last captured switch word, extended to DATA_WIDTH
input_ready  output  1  one-cycle pulse; input_data is valid in the same cycle
waiting  output  1  high while armed and waiting for a press (drives an LED)

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset=0, asynchronous):
  - input_data=0, input_ready=0, waiting=0.
  - Synchroniser flops = released (button) and 0 (switches); debounced level = released; counter=0; FSM=IDLE.
- Synchronisers: two flops on button_n and on each switch bit.
- Debounce:
  - Counter runs while the synced button differs from the debounced level; it clears whenever they match.
  - The debounced level flips on the edge where the counter reaches DEBOUNCE_CYCLES, then the counter clears.
  - A press_edge flag is registered on the released->pressed flip of the debounced level.
  - Debounce runs continuously in every FSM state.
- FSM states: IDLE, ARMED, CAPTURE, WAIT_RELEASE.
  - IDLE: waiting=0. input_request=1 -> ARMED. Presses in IDLE are ignored.
  - ARMED: waiting=1.
    - input_request=0 -> IDLE (abort, no capture, no pulse).
    - press_edge=1 -> CAPTURE.
    - A button already held when ARMED is entered does not capture; a fresh release and press is required.
  - CAPTURE (exactly one cycle): input_ready=1; input_data loaded with the synced switches; waiting=0 -> WAIT_RELEASE.
  - WAIT_RELEASE: when the debounced level returns to released, go to IDLE. This gives one capture per press, even if input_request is still high for the next IN instruction.
- Latency: with the button held steady, input_ready is high in the cycle after the (3+DEBOUNCE_CYCLES)-th rising edge following the first edge that samples button_n=0.
- input_data holds its value between captures and is never cleared except by reset.
- Default extension: zero-extend switches to DATA_WIDTH.
- Simultaneous press_edge and input_request falling in ARMED: the abort wins and no capture occurs.
- Bounce shorter than DEBOUNCE_CYCLES clears the counter and causes no level change.
- reset asserted mid-operation: all state returns to reset values immediately; an in-flight capture is lost.

Optional Feature:
- Macro: INPUT_PORT_SIGN_EXTEND_EN.
- Defined: input_data = switches sign-extended from bit SWITCH_WIDTH-1, so the switches act as a signed two's-complement operand.
- Undefined: zero extension as described in Behaviour.

Test Plan:
- DEBOUNCE_CYCLES=4; reset low for 3 cycles, then high -> input_data=0, input_ready=0, waiting=0; FSM stays in IDLE with no request.
- DEBOUNCE_CYCLES=4; input_request=1, switches=18'h00025, button_n=0 held -> waiting=1 until input_ready pulses for exactly 1 cycle at edge 3+4+1=8; input_data=32'h00000025; waiting=0 afterwards.
- Button held after the capture above, input_request kept at 1 -> no second pulse; release for >=4 cycles, then press again with switches=18'h3FFFF -> second pulse; input_data=32'h0003FFFF, or 32'hFFFFFFFF with INPUT_PORT_SIGN_EXTEND_EN defined.
- DEBOUNCE_CYCLES=4; while ARMED, button_n toggles with 3-cycle low glitches 5 times -> no input_ready; waiting stays 1.
- In ARMED, drop input_request, then press for 10 cycles -> no pulse; input_data unchanged; FSM returns to IDLE.
- During the counting phase of a press, assert reset for 1 cycle -> all outputs 0 immediately; after reset with request=1, a held press needs a full 3+DEBOUNCE_CYCLES cycles from the first post-reset sample before it captures.

Source files
------------

// File: rtl/input_port_controller_if.sv
// Handshake/bus bundle between the input port controller and its consumer.
// master: the controller side; slave: the processor/bench side.
interface input_port_controller_if #(
  parameter int SWITCH_WIDTH = 18,
  parameter int DATA_WIDTH   = 32
);
  logic [SWITCH_WIDTH-1:0] switches;
  logic                    button_n;
  logic                    input_request;
  logic [DATA_WIDTH-1:0]   input_data;
  logic                    input_ready;
  logic                    waiting;

  modport master (
    input  switches, button_n, input_request,
    output input_data, input_ready, waiting
  );

  modport slave (
    output switches, button_n, input_request,
    input  input_data, input_ready, waiting
  );
endinterface

// File: rtl/input_port_controller.sv
// Input port controller: supplies the word read by the IN instruction.
// Synchronises switches and confirm key, debounces the key, and on a fresh
// debounced press while a request is pending captures the switches and
// pulses input_ready for one cycle.
// Optional: define INPUT_PORT_SIGN_EXTEND_EN to sign-extend the switch word
// from its top bit instead of zero-extending it.
module input_port_controller #(
  parameter int SWITCH_WIDTH    = 18,
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic                 clock,
  input logic                 reset,
  input_port_controller_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, WAIT_RELEASE} state_t;

  state_t                  state, state_nxt;
  logic                    btn_s1, btn_s2;
  logic [SWITCH_WIDTH-1:0] sw_s1, sw_s2;
  logic                    btn_db;      // debounced level, 1 = released
  logic [CW-1:0]           cnt;
  logic                    press_edge;
  logic                    load;
  logic [DATA_WIDTH-1:0]   sw_ext;

`ifdef INPUT_PORT_SIGN_EXTEND_EN
  assign sw_ext = DATA_WIDTH'($signed(sw_s2));
`else
  assign sw_ext = DATA_WIDTH'(sw_s2);
`endif

  // Two-flop synchronisers; the key idles released so its flops reset to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= bus.button_n;
      btn_s2 <= btn_s1;
      sw_s1  <= bus.switches;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: level follows the synced key only after it has disagreed for
  // DEBOUNCE_CYCLES consecutive clocks; a released->pressed flip raises press_edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_db     <= 1'b1;
      cnt        <= '0;
      press_edge <= 1'b0;
    end else begin
      press_edge <= 1'b0;
      if (btn_s2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt        <= '0;
        btn_db     <= btn_s2;
        press_edge <= ~btn_s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and Moore outputs; an abort in ARMED beats a simultaneous press.
  always_comb begin
    state_nxt       = state;
    load            = 1'b0;
    bus.input_ready = 1'b0;
    bus.waiting     = 1'b0;
    case (state)
      IDLE: if (bus.input_request) state_nxt = ARMED;
      ARMED: begin
        bus.waiting = 1'b1;
        if (!bus.input_request) begin
          state_nxt = IDLE;
        end else if (press_edge) begin
          state_nxt = CAPTURE;
          load      = 1'b1;
        end
      end
      CAPTURE: begin
        bus.input_ready = 1'b1;
        state_nxt       = WAIT_RELEASE;
      end
      WAIT_RELEASE: if (btn_db) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data register loads on entry to CAPTURE so it is valid alongside input_ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    bus.input_data <= '0;
    else if (load) bus.input_data <= sw_ext;
  end
endmodule
